// File: rtl/csr_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// csr_ctrl_pkg
//
// Shared types and constants for the CSR latch-bank write controller.
//
//   state_t   : controller states (IDLE, SETUP, PULSE, HOLD)
//   CNT_W     : width of the PULSE down-counter (covers PULSE_CYC 1..15)
//   REQ0/REQ1 : requester index encodings used by the arbiter and the
//               controller's owner/last registers
// ---------------------------------------------------------------------------
package csr_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        PULSE = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam int CNT_W = 4;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/csr_latch_write_ctrl_rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
//
// Two-input round-robin arbiter (purely combinational). The round-robin
// pointer lives in the caller, which updates it with the returned winner.
//
// Ports:
//   req[1:0] in   request vector, bit n from requester n
//   last     in   index of the previously granted requester
//   update   in   arbitration window; valid is suppressed when low
//   win      out  index of the winning requester
//   valid    out  high when update is high and at least one req is high
// ---------------------------------------------------------------------------
module rr_arb2
    import csr_ctrl_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    input  logic       update,
    output logic       win,
    output logic       valid
);

    always_comb begin
        valid = update & (req[0] | req[1]);
        win   = REQ0;
        if (req[0] && req[1]) begin
            // Tie: whoever was not served last goes first.
            win = (last == REQ0) ? REQ1 : REQ0;
        end else if (req[1]) begin
            win = REQ1;
        end else begin
            win = REQ0;
        end
    end

endmodule

// File: rtl/csr_latch_write_ctrl.sv
// ---------------------------------------------------------------------------
// csr_latch_write_ctrl
//
// Write controller and two-way round-robin arbiter for a bank of WIDTH
// clocked SR latches sharing one enable. Every write runs
//   SETUP (C low, S/R presented) -> PULSE (C high, PULSE_CYC cycles)
//   -> HOLD (C low, S/R still held) -> IDLE
// so S/R never move while C is high and S=R=1 is never presented.
//
// Parameters:
//   WIDTH     number of latch bits
//   PULSE_CYC cycles of C high per write, legal range 1..15
//
// Ports:
//   clk            in   rising-edge clock
//   rst            in   asynchronous active-high reset (aborts any write)
//   req0/req1      in   write requests, held until the matching done
//   wdata0/wdata1  in   write data, captured at grant
//   gnt0/gnt1      out  one-cycle grant pulses (SETUP cycle)
//   done0/done1    out  one-cycle completion pulses (HOLD cycle)
//   latch_S/_R     out  per-bit set/reset inputs of the latch bank
//   latch_C        out  shared latch enable
//   busy           out  high whenever the controller is not IDLE
//
// All outputs come straight from flops; there is no combinational path
// from any input to any output.
// ---------------------------------------------------------------------------
module csr_latch_write_ctrl
    import csr_ctrl_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int PULSE_CYC = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] wdata0,
    input  logic             req1,
    input  logic [WIDTH-1:0] wdata1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH-1:0] latch_S,
    output logic [WIDTH-1:0] latch_R,
    output logic             latch_C,
    output logic             busy
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PULSE_CYC - 1);

    state_t           state;
    logic             last;
    logic             owner;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] wreg;
    logic [WIDTH-1:0] rreg;

    logic             arb_en;
    logic             arb_win;
    logic             arb_valid;
    logic [WIDTH-1:0] wsel;

    assign arb_en = (state == IDLE);
    assign wsel   = (arb_win == REQ1) ? wdata1 : wdata0;

    rr_arb2 u_arb (
        .req    ({req1, req0}),
        .last   (last),
        .update (arb_en),
        .win    (arb_win),
        .valid  (arb_valid)
    );

    // wreg/rreg are the captured data and its complement; they drive
    // latch_S/latch_R directly so those outputs are pure flop outputs and
    // stay frozen from SETUP through HOLD regardless of wdata changes.
    assign latch_S = wreg;
    assign latch_R = rreg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            last    <= REQ1;
            owner   <= REQ0;
            cnt     <= '0;
            wreg    <= '0;
            rreg    <= '0;
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            done0   <= 1'b0;
            done1   <= 1'b0;
            latch_C <= 1'b0;
            busy    <= 1'b0;
        end else begin
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            done0 <= 1'b0;
            done1 <= 1'b0;

            unique case (state)
                IDLE: begin
                    latch_C <= 1'b0;
                    if (arb_valid) begin
                        state <= SETUP;
                        owner <= arb_win;
                        last  <= arb_win;
                        wreg  <= wsel;
                        rreg  <= ~wsel;
                        gnt0  <= (arb_win == REQ0);
                        gnt1  <= (arb_win == REQ1);
                        busy  <= 1'b1;
                    end
                end

                SETUP: begin
                    state   <= PULSE;
                    cnt     <= CNT_LOAD;
                    latch_C <= 1'b1;
                end

                PULSE: begin
                    if (cnt == '0) begin
                        state   <= HOLD;
                        latch_C <= 1'b0;
                        done0   <= (owner == REQ0);
                        done1   <= (owner == REQ1);
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                HOLD: begin
                    // C already low for a full cycle; S/R may now return to 0.
                    state   <= IDLE;
                    wreg    <= '0;
                    rreg    <= '0;
                    latch_C <= 1'b0;
                    busy    <= 1'b0;
                end

                default: begin
                    state   <= IDLE;
                    wreg    <= '0;
                    rreg    <= '0;
                    latch_C <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_csr_latch_write_ctrl.sv
// ---------------------------------------------------------------------------
// tb_csr_latch_write_ctrl
//
// Directed bench: expected transactions are queued when requests are
// driven; a negedge monitor pops them on each grant and follows the write
// through PULSE and HOLD, also tracking an SR latch model of the bank.
// A second instance built with PULSE_CYC=1 is exercised directly.
// ---------------------------------------------------------------------------
module tb_csr_latch_write_ctrl;

    localparam int W = 8;
    localparam int P = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req0 = 1'b0, req1 = 1'b0;
    logic [W-1:0] wdata0 = '0, wdata1 = '0;
    logic         gnt0, gnt1, done0, done1, latch_C, busy;
    logic [W-1:0] latch_S, latch_R;

    logic         b_req0 = 1'b0, b_req1 = 1'b0;
    logic [W-1:0] b_wdata0 = '0, b_wdata1 = '0;
    logic         b_gnt0, b_gnt1, b_done0, b_done1, b_latch_C, b_busy;
    logic [W-1:0] b_latch_S, b_latch_R;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int           who;
        logic [W-1:0] data;
        int           gcyc;
    } txn_t;

    txn_t         sbq[$];
    txn_t         cur;
    bit           active = 0;
    int           g = 0;
    logic [W-1:0] q_model = '0;
    logic         prev_c = 1'b0;
    logic [W-1:0] prev_s = '0, prev_r = '0;

    csr_latch_write_ctrl #(.WIDTH(W), .PULSE_CYC(P)) u_dut (
        .clk(clk), .rst(rst),
        .req0(req0), .wdata0(wdata0), .req1(req1), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .latch_S(latch_S), .latch_R(latch_R), .latch_C(latch_C), .busy(busy)
    );

    csr_latch_write_ctrl #(.WIDTH(W), .PULSE_CYC(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .req0(b_req0), .wdata0(b_wdata0), .req1(b_req1), .wdata1(b_wdata1),
        .gnt0(b_gnt0), .gnt1(b_gnt1), .done0(b_done0), .done1(b_done1),
        .latch_S(b_latch_S), .latch_R(b_latch_R), .latch_C(b_latch_C), .busy(b_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Monitor: samples at negedge, well away from the active edge.
    always @(negedge clk) begin : mon
        int           d;
        logic [W-1:0] inv;
        if (rst) begin
            active = 0;
            prev_c = 1'b0;
        end else begin
            if (latch_C) q_model = (q_model & ~latch_R) | latch_S;

            chk("inv_s_and_r", 32'(latch_S & latch_R), 32'd0);
            chk("inv_gnt_excl", 32'(gnt0 & gnt1), 32'd0);
            chk("inv_done_excl", 32'(done0 & done1), 32'd0);
            if (prev_c && latch_C) begin
                chk("inv_s_stable", 32'(latch_S), 32'(prev_s));
                chk("inv_r_stable", 32'(latch_R), 32'(prev_r));
            end

            if (gnt0 || gnt1) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_gnt", 32'(gnt0 | gnt1), 32'd0);
                end else begin
                    cur    = sbq.pop_front();
                    active = 1;
                    g      = cyc;
                    chk("gnt_who", 32'(gnt1), 32'(cur.who == 1));
                    chk("gnt_cycle", 32'(cyc), 32'(cur.gcyc));
                end
            end

            d   = active ? (cyc - g) : -1;
            inv = ~cur.data;
            chk("latch_C", 32'(latch_C), 32'(active && d >= 1 && d <= P));
            chk("done0", 32'(done0), 32'(active && d == P + 1 && cur.who == 0));
            chk("done1", 32'(done1), 32'(active && d == P + 1 && cur.who == 1));
            chk("busy", 32'(busy), 32'(active && d <= P + 1));
            if (active && d <= P + 1) begin
                chk("latch_S", 32'(latch_S), 32'(cur.data));
                chk("latch_R", 32'(latch_R), 32'(inv));
            end
            if (active && d == P + 1) chk("q_model", 32'(q_model), 32'(cur.data));
            if (active && d == P + 2) active = 0;

            prev_c = latch_C;
            prev_s = latch_S;
            prev_r = latch_R;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic push(input int who, input logic [W-1:0] data, input int gcyc);
        txn_t t;
        t.who  = who;
        t.data = data;
        t.gcyc = gcyc;
        sbq.push_back(t);
    endtask

    initial begin
        // Reset state
        step(2);
        chk("rst_gnt", 32'({gnt1, gnt0}), 32'd0);
        chk("rst_done", 32'({done1, done0}), 32'd0);
        chk("rst_SRC", 32'({latch_S, latch_R, latch_C}), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        step(2);

        // 1: single write
        req0 = 1'b1; wdata0 = 8'hA5;
        push(0, 8'hA5, cyc + 1);
        step(4);
        req0 = 1'b0;
        step(3);
        chk("t1_q", 32'(q_model), 32'h0000_00A5);

        // 2: simultaneous requests straight after reset
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(1);
        req0 = 1'b1; wdata0 = 8'h0F;
        req1 = 1'b1; wdata1 = 8'hF0;
        push(0, 8'h0F, cyc + 1);
        push(1, 8'hF0, cyc + 6);
        step(4);
        req0 = 1'b0;
        step(5);
        req1 = 1'b0;
        step(3);
        chk("t2_q", 32'(q_model), 32'h0000_00F0);

        // 3: back-to-back fairness, both held for four writes
        req0 = 1'b1; wdata0 = 8'h11;
        req1 = 1'b1; wdata1 = 8'h22;
        push(0, 8'h11, cyc + 1);
        push(1, 8'h22, cyc + 6);
        push(0, 8'h11, cyc + 11);
        push(1, 8'h22, cyc + 16);
        step(17);
        req0 = 1'b0;
        req1 = 1'b0;
        step(5);
        chk("t3_q", 32'(q_model), 32'h0000_0022);

        // 4: wdata change after grant is ignored
        req0 = 1'b1; wdata0 = 8'h3C;
        push(0, 8'h3C, cyc + 1);
        step(2);
        wdata0 = 8'hFF;
        step(2);
        req0 = 1'b0;
        step(3);
        chk("t4_q", 32'(q_model), 32'h0000_003C);

        // 5: reset in the middle of the pulse, then a normal write
        req1 = 1'b1; wdata1 = 8'h66;
        push(1, 8'h66, cyc + 1);
        step(2);
        rst = 1'b1;
        #1;
        chk("t5_C", 32'(latch_C), 32'd0);
        chk("t5_SR", 32'({latch_S, latch_R}), 32'd0);
        chk("t5_gnt_done", 32'({gnt0, gnt1, done0, done1}), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        step(1);
        rst = 1'b0;
        wdata1 = 8'h99;
        push(1, 8'h99, cyc + 1);
        step(4);
        req1 = 1'b0;
        step(3);
        chk("t5_q", 32'(q_model), 32'h0000_0099);

        // 6: PULSE_CYC=1 instance
        b_req0 = 1'b1; b_wdata0 = 8'hC3;
        step(1);
        chk("t6_gnt0", 32'(b_gnt0), 32'd1);
        chk("t6_C_setup", 32'(b_latch_C), 32'd0);
        chk("t6_S", 32'(b_latch_S), 32'h0000_00C3);
        step(1);
        chk("t6_C_pulse", 32'(b_latch_C), 32'd1);
        chk("t6_done_early", 32'(b_done0), 32'd0);
        step(1);
        chk("t6_C_hold", 32'(b_latch_C), 32'd0);
        chk("t6_done0", 32'(b_done0), 32'd1);
        chk("t6_S_hold", 32'(b_latch_S), 32'h0000_00C3);
        b_req0 = 1'b0;
        step(1);
        chk("t6_busy", 32'(b_busy), 32'd0);
        chk("t6_done_after", 32'(b_done0), 32'd0);
        step(2);

        // All queued writes must have been granted and finished.
        chk("sb_empty", 32'(sbq.size()), 32'd0);
        chk("sb_idle", 32'(active), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
